// File: rtl/lc3_run_ctrl_pkg.sv
// lc3_ctrl_pkg: state, mode and button-index encodings shared by the run controller
package lc3_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_HALT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;
    localparam logic [1:0] MODE_FREE  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BOUND = 2'b10;
    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_SRST = 2;
endpackage

// File: rtl/lc3_run_ctrl_if.sv
// lc3_run_ctrl_if: board-side controls in, core reset/enable and status out
interface lc3_run_ctrl_if #(
    parameter int NUM_BTN = 4,
    parameter int CYC_W   = 32
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [1:0]         mode;
    logic [CYC_W-1:0]   run_limit;
    logic               core_rst;
    logic               core_clk_en;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [CYC_W-1:0]   cycle_count;
    logic               done;
    logic [2:0]         state;
    modport master (
        output btn_raw, mode, run_limit,
        input  core_rst, core_clk_en, btn_level, btn_pulse, cycle_count, done, state
    );
    modport slave (
        input  btn_raw, mode, run_limit,
        output core_rst, core_clk_en, btn_level, btn_pulse, cycle_count, done, state
    );
endinterface

// File: rtl/lc3_run_ctrl_btn_debounce.sv
// lc3_btn_debounce: one button channel, 2-FF synchronizer, stability counter and rising-edge pulse
module lc3_btn_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk_0,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          accept;
    assign accept = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYC - 1));
    // accept a new level only after DEBOUNCE_CYC consecutive disagreeing samples
    always_ff @(posedge clk_0) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            cnt   <= (sync[1] == level || accept) ? '0 : cnt + 1'b1;
            level <= accept ? sync[1] : level;
            pulse <= accept && sync[1];
        end
    end
endmodule

// File: rtl/lc3_run_ctrl.sv
// lc3_run_ctrl: debounced buttons, stretched core reset and free/step/bounded execution gating
module lc3_run_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int RST_HOLD     = 10,
    parameter int CYC_W        = 32
) (
    input logic          clk_0,
    input logic          rst,
    lc3_run_ctrl_if.slave bus
);
    localparam int HW = $clog2(RST_HOLD + 1);
    state_e           st, st_n;
    logic [HW-1:0]    hold, hold_n;
    logic [CYC_W-1:0] lim, lim_n, run_cnt, run_cnt_n, cnt_n;
    logic [CYC_W:0]   run_sum;
    logic             bnd, bnd_n, clk_en_n;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        lc3_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk_0 (clk_0),
            .rst   (rst),
            .raw   (bus.btn_raw[i]),
            .level (bus.btn_level[i]),
            .pulse (bus.btn_pulse[i])
        );
    end

    // next state plus next registered outputs; limit and bounded flag latch on RUN entry
    always_comb begin
        st_n      = st;
        hold_n    = '0;
        lim_n     = lim;
        bnd_n     = bnd;
        run_cnt_n = '0;
        run_sum   = {1'b0, run_cnt} + (CYC_W+1)'(bus.core_clk_en);
        case (st)
            ST_RESET: begin
                hold_n = hold + 1'b1;
                if (hold == HW'(RST_HOLD - 1)) st_n = (bus.mode == MODE_FREE) ? ST_RUN : ST_HALT;
            end
            ST_HALT: st_n = bus.btn_pulse[BTN_RUN] ? ST_RUN : bus.btn_pulse[BTN_STEP] ? ST_STEP : ST_HALT;
            ST_STEP: st_n = ST_HALT;
            ST_RUN: begin
                run_cnt_n = run_sum[CYC_W-1:0];
                if (bus.btn_pulse[BTN_RUN]) st_n = ST_HALT;
                else if (bnd && run_sum >= {1'b0, lim}) st_n = ST_DONE;
            end
            default: st_n = ST_DONE;
        endcase
        if (bus.btn_pulse[BTN_SRST]) begin
            st_n   = ST_RESET;
            hold_n = '0;
        end
        if (st_n == ST_RUN && st != ST_RUN) begin
            bnd_n     = bus.mode == MODE_BOUND;
            lim_n     = bus.run_limit;
            run_cnt_n = '0;
        end
        clk_en_n = (st_n == ST_STEP) || (st_n == ST_RUN && !(bnd_n && lim_n == '0));
        cnt_n    = (st_n == ST_RESET) ? '0 :
                   (bus.core_clk_en && bus.cycle_count != '1) ? bus.cycle_count + 1'b1 : bus.cycle_count;
    end

    // state and all outputs registered together
    always_ff @(posedge clk_0) begin
        if (rst) begin
            st              <= ST_RESET;
            hold            <= '0;
            lim             <= '0;
            bnd             <= 1'b0;
            run_cnt         <= '0;
            bus.core_rst    <= 1'b1;
            bus.core_clk_en <= 1'b0;
            bus.done        <= 1'b0;
            bus.cycle_count <= '0;
        end else begin
            st              <= st_n;
            hold            <= hold_n;
            lim             <= lim_n;
            bnd             <= bnd_n;
            run_cnt         <= run_cnt_n;
            bus.core_rst    <= st_n == ST_RESET;
            bus.core_clk_en <= clk_en_n;
            bus.done        <= st_n == ST_DONE;
            bus.cycle_count <= cnt_n;
        end
    end

    assign bus.state = st;
endmodule

// File: tb/tb_lc3_run_ctrl.sv
// tb_lc3_run_ctrl: self-checking bench for lc3_run_ctrl
module tb_lc3_run_ctrl;
    import lc3_ctrl_pkg::*;

    typedef struct {
        logic [3:0]  btn;
        logic [1:0]  mode;
        logic [31:0] lim;
        int          wait_cyc;
        logic [2:0]  st;
        logic        en;
        logic        dn;
        int          cnt;
    } vec_t;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   en_total = 0;
    vec_t tbl[12];

    lc3_run_ctrl_if #(.NUM_BTN(4), .CYC_W(32)) bus0();
    lc3_run_ctrl_if #(.NUM_BTN(4), .CYC_W(4))  bus1();

    lc3_run_ctrl #(.NUM_BTN(4), .DEBOUNCE_CYC(16), .RST_HOLD(10), .CYC_W(32)) u0 (
        .clk_0 (clk), .rst (rst0), .bus (bus0)
    );
    lc3_run_ctrl #(.NUM_BTN(4), .DEBOUNCE_CYC(16), .RST_HOLD(10), .CYC_W(4)) u1 (
        .clk_0 (clk), .rst (rst1), .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_total <= en_total + int'(bus0.core_clk_en);

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] m);
        bus0.btn_raw = m;
        repeat (20) @(negedge clk);
        bus0.btn_raw = '0;
        repeat (22) @(negedge clk);
    endtask

    initial begin
        int   np, pk, rh, lim, e0;
        logic v, d1, hl, lvl, pm;
        int   run, hold;
        tbl[0]  = '{4'h0, 2'b01, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, 0};
        tbl[1]  = '{4'h1, 2'b01, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, 1};
        tbl[2]  = '{4'h1, 2'b11, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, 2};
        tbl[3]  = '{4'h1, 2'b01, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, 3};
        tbl[4]  = '{4'h2, 2'b10, 32'd100, 100, ST_DONE, 1'b0, 1'b1, 103};
        tbl[5]  = '{4'h2, 2'b10, 32'd100, 0,   ST_DONE, 1'b0, 1'b1, 103};
        tbl[6]  = '{4'h4, 2'b10, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, 0};
        tbl[7]  = '{4'h2, 2'b10, 32'd0,   0,   ST_DONE, 1'b0, 1'b1, 0};
        tbl[8]  = '{4'h4, 2'b01, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, 0};
        tbl[9]  = '{4'h1, 2'b00, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, 1};
        tbl[10] = '{4'h3, 2'b01, 32'd0,   0,   ST_RUN,  1'b1, 1'b0, -1};
        tbl[11] = '{4'h2, 2'b01, 32'd0,   0,   ST_HALT, 1'b0, 1'b0, -1};
        bus0.btn_raw = '0; bus0.mode = MODE_FREE; bus0.run_limit = '0;
        bus1.btn_raw = '0; bus1.mode = MODE_FREE; bus1.run_limit = '0;

        // reset values, stretched core reset, free-run start
        repeat (3) @(negedge clk);
        chk("rst_state", bus0.state, ST_RESET);
        chk("rst_core_rst", bus0.core_rst, 1);
        chk("rst_clk_en", bus0.core_clk_en, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_count", bus0.cycle_count, 0);
        chk("rst_level", bus0.btn_level, 0);
        chk("rst_pulse", bus0.btn_pulse, 0);
        rst0 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("hold_core_rst_%0d", k), bus0.core_rst, k < 10);
            chk($sformatf("hold_clk_en_%0d", k), bus0.core_clk_en, k >= 10);
            chk($sformatf("hold_count_%0d", k), bus0.cycle_count, k >= 10 ? k - 10 : 0);
        end

        // glitch rejection and clean press pulse timing
        bus0.btn_raw[0] = 1'b1;
        repeat (5) @(negedge clk);
        bus0.btn_raw[0] = 1'b0;
        np = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            np += int'(bus0.btn_pulse[0]);
        end
        chk("glitch_pulses", np, 0);
        chk("glitch_level", bus0.btn_level[0], 0);
        bus0.btn_raw[0] = 1'b1;
        np = 0; pk = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus0.btn_pulse[0]) begin np++; pk = k; end
        end
        chk("press_pulses", np, 1);
        chk("press_pulse_edge", pk, 18);
        chk("press_level", bus0.btn_level[0], 1);
        bus0.btn_raw[0] = 1'b0;
        repeat (25) @(negedge clk);

        // soft reset during free run
        chk("free_state", bus0.state, ST_RUN);
        bus0.btn_raw[2] = 1'b1;
        pk = -1;
        for (int k = 1; k <= 40 && pk < 0; k++) begin
            @(negedge clk);
            if (bus0.btn_pulse[2]) pk = k;
        end
        chk("srst_pulse_edge", pk, 18);
        @(negedge clk);
        chk("srst_state", bus0.state, ST_RESET);
        chk("srst_count", bus0.cycle_count, 0);
        chk("srst_clk_en", bus0.core_clk_en, 0);
        rh = int'(bus0.core_rst);
        for (int k = 0; k < 30 && bus0.core_rst; k++) begin
            @(negedge clk);
            rh += int'(bus0.core_rst);
        end
        chk("srst_core_rst_cycles", rh, 10);
        bus0.btn_raw[2] = 1'b0;
        repeat (25) @(negedge clk);

        // table-driven step/run/bounded/soft-reset sequence starting in HALT
        bus0.mode = MODE_STEP;
        rst0 = 1'b1;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            bus0.mode = tbl[i].mode;
            bus0.run_limit = tbl[i].lim;
            if (tbl[i].btn != 4'h0) press(tbl[i].btn);
            repeat (tbl[i].wait_cyc) @(negedge clk);
            chk($sformatf("tbl%0d_state", i), bus0.state, tbl[i].st);
            chk($sformatf("tbl%0d_clk_en", i), bus0.core_clk_en, tbl[i].en);
            chk($sformatf("tbl%0d_done", i), bus0.done, tbl[i].dn);
            chk($sformatf("tbl%0d_core_rst", i), bus0.core_rst, 0);
            if (tbl[i].cnt >= 0) chk($sformatf("tbl%0d_count", i), bus0.cycle_count, tbl[i].cnt);
        end

        // random bounded runs: enabled cycles must equal the limit
        for (int it = 0; it < 3; it++) begin
            lim = int'($urandom_range(1, 60));
            bus0.mode = MODE_BOUND;
            bus0.run_limit = lim;
            press(4'h4);
            e0 = en_total;
            press(4'h2);
            for (int k = 0; k < 200 && !bus0.done; k++) @(negedge clk);
            chk($sformatf("bnd%0d_done", it), bus0.done, 1);
            chk($sformatf("bnd%0d_enabled", it), en_total - e0, lim);
            chk($sformatf("bnd%0d_count", it), bus0.cycle_count, lim);
            chk($sformatf("bnd%0d_state", it), bus0.state, ST_DONE);
        end

        // random bouncing on the pass-through channel against a run-length model
        v = 1'b0; d1 = 1'b0; hl = 1'b0; lvl = 1'b0; run = 100; hold = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            pm = 1'b0;
            if (hl != lvl && run >= 16) begin
                lvl = hl;
                pm  = hl;
            end
            run = (d1 == hl) ? run + 1 : 1;
            hl  = d1;
            d1  = v;
            chk($sformatf("ch3_level_%0d", n), bus0.btn_level[3], lvl);
            chk($sformatf("ch3_pulse_%0d", n), bus0.btn_pulse[3], pm);
            if (hold == 0) begin
                v    = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 24));
            end
            hold--;
            bus0.btn_raw[3] = v;
        end
        bus0.btn_raw[3] = 1'b0;

        // narrow counter saturates; rst mid-run restores reset outputs
        rst1 = 1'b0;
        repeat (30) @(negedge clk);
        chk("sat_count", bus1.cycle_count, 15);
        chk("sat_clk_en", bus1.core_clk_en, 1);
        chk("sat_state", bus1.state, ST_RUN);
        rst1 = 1'b1;
        @(negedge clk);
        chk("midrst_state", bus1.state, ST_RESET);
        chk("midrst_core_rst", bus1.core_rst, 1);
        chk("midrst_clk_en", bus1.core_clk_en, 0);
        chk("midrst_count", bus1.cycle_count, 0);
        chk("midrst_done", bus1.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
